// File: rtl/aes256_key_schedule_seq_pkg.sv
// Shared constants, FSM state type and GF(2^8) helpers for the AES-256 key schedule sequencer.
// Byte 0 of every word and key sits in bits [7:0].
package aes_key_sched_pkg;

  localparam int AES256_KEY_LENGTH       = 256;
  localparam int AES_BLOCK_SIZE          = 128;
  localparam int AES_WORD_SIZE           = 32;
  localparam int AES256_NUMBER_OF_ROUNDS = 14;
  localparam int NUM_ROUND_KEYS          = AES256_NUMBER_OF_ROUNDS + 1;
  localparam int IDX_W                   = 4;

  localparam int KEY_W  = AES256_KEY_LENGTH;
  localparam int BLK_W  = AES_BLOCK_SIZE;
  localparam int WORD_W = AES_WORD_SIZE;

  typedef enum logic {IDLE, EMIT} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (a^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox(w[8*i +: 8]);
    return r;
  endfunction

endpackage

// File: rtl/aes256_key_schedule_seq_if.sv
// Key-load and round-key stream signals of the AES-256 key schedule sequencer.
interface aes256_key_schedule_seq_if;
  import aes_key_sched_pkg::*;

  logic [KEY_W-1:0] Key;
  logic             Key_valid;
  logic             Key_ready;
  logic [BLK_W-1:0] Round_key;
  logic [IDX_W-1:0] Round_key_index;
  logic             Round_key_last;
  logic             Round_key_valid;
  logic             Round_key_ready;
  logic             Replay;

  modport master (
    output Key, Key_valid, Round_key_ready, Replay,
    input  Key_ready, Round_key, Round_key_index, Round_key_last, Round_key_valid
  );

  modport slave (
    input  Key, Key_valid, Round_key_ready, Replay,
    output Key_ready, Round_key, Round_key_index, Round_key_last, Round_key_valid
  );
endinterface

// File: rtl/aes256_key_schedule_seq_expansion.sv
// Combinational single-round AES-256 expansion: next round key from the two previous ones.
module aes256_key_expansion_port
  import aes_key_sched_pkg::*;
(
  input  logic [IDX_W-1:0] Round_number,
  input  logic [KEY_W-1:0] Input_key,
  output logic [BLK_W-1:0] Output_key
);

  logic [WORD_W-1:0] w_last;
  logic [WORD_W-1:0] temp;
  logic [WORD_W-1:0] o0, o1, o2, o3;
  logic [IDX_W-1:0]  sh;
  logic [7:0]        rcon;
  logic              unused_mid;

  assign w_last     = Input_key[KEY_W-1 -: WORD_W];
  assign unused_mid = ^Input_key[KEY_W-WORD_W-1:BLK_W];

  // Even rounds start a new 8-word group (RotWord + Rcon); odd rounds only SubWord.
  always_comb begin
    sh   = IDX_W'(Round_number >> 1) - IDX_W'(1);
    rcon = 8'h01 << sh;
    if (!Round_number[0]) temp = sub_word({w_last[7:0], w_last[31:8]}) ^ {24'h0, rcon};
    else                  temp = sub_word(w_last);
  end

  assign o0 = Input_key[31:0]   ^ temp;
  assign o1 = Input_key[63:32]  ^ o0;
  assign o2 = Input_key[95:64]  ^ o1;
  assign o3 = Input_key[127:96] ^ o2;
  assign Output_key = {o3, o2, o1, o0};

endmodule

// File: rtl/aes256_key_schedule_seq.sv
// AES-256 key schedule sequencer: loads a 256-bit key and streams round keys 0..14.
// Optional replay store enabled by defining AES256_KEY_SCHEDULE_CACHE_EN.
module aes256_key_schedule_seq
  import aes_key_sched_pkg::*;
(
  input logic                      Clk,
  input logic                      Rst,
  aes256_key_schedule_seq_if.slave bus
);

  state_t           state_p0, state_nx;
  logic [KEY_W-1:0] window_p0, window_nx;
  logic [BLK_W-1:0] rk_p0, rk_nx;
  logic [IDX_W-1:0] idx_p0, idx_nx, idx_inc;
  logic             vld_p0, vld_nx;
  logic [BLK_W-1:0] exp_key;
  logic             is_last;

`ifdef AES256_KEY_SCHEDULE_CACHE_EN
  logic [BLK_W-1:0] store_mem [NUM_ROUND_KEYS];
  logic             cache_vld_p0, cache_vld_nx;
  logic             replay_p0, replay_nx;
  logic             store_we;
`else
  logic             unused_replay;
  assign unused_replay = bus.Replay;
`endif

  assign idx_inc = idx_p0 + IDX_W'(1);
  assign is_last = (idx_p0 == IDX_W'(NUM_ROUND_KEYS - 1));

  aes256_key_expansion_port u_expand (
    .Round_number (idx_inc),
    .Input_key    (window_p0),
    .Output_key   (exp_key)
  );

  always_comb begin
    state_nx  = state_p0;
    window_nx = window_p0;
    rk_nx     = rk_p0;
    idx_nx    = idx_p0;
    vld_nx    = vld_p0;
`ifdef AES256_KEY_SCHEDULE_CACHE_EN
    cache_vld_nx = cache_vld_p0;
    replay_nx    = replay_p0;
    store_we     = 1'b0;
`endif
    case (state_p0)
      IDLE: begin
        if (bus.Key_valid) begin
          window_nx = bus.Key;
          rk_nx     = bus.Key[BLK_W-1:0];
          idx_nx    = '0;
          vld_nx    = 1'b1;
          state_nx  = EMIT;
`ifdef AES256_KEY_SCHEDULE_CACHE_EN
          cache_vld_nx = 1'b0;
          replay_nx    = 1'b0;
          store_we     = 1'b1;
        end else if (bus.Replay && cache_vld_p0) begin
          rk_nx     = store_mem[0];
          idx_nx    = '0;
          vld_nx    = 1'b1;
          state_nx  = EMIT;
          replay_nx = 1'b1;
`endif
        end
      end
      EMIT: begin
        if (vld_p0 && bus.Round_key_ready) begin
          if (is_last) begin
            vld_nx   = 1'b0;
            state_nx = IDLE;
`ifdef AES256_KEY_SCHEDULE_CACHE_EN
            cache_vld_nx = ~replay_p0 | cache_vld_p0;
`endif
          end else begin
            idx_nx = idx_inc;
            // Round key 1 is the upper key half; from then on the window slides.
            if (idx_p0 == '0) begin
              rk_nx = window_p0[KEY_W-1:BLK_W];
            end else begin
              rk_nx     = exp_key;
              window_nx = {exp_key, window_p0[KEY_W-1:BLK_W]};
            end
`ifdef AES256_KEY_SCHEDULE_CACHE_EN
            store_we = ~replay_p0;
            if (replay_p0) rk_nx = store_mem[idx_inc];
`endif
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: output register, sliding window and control.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_p0  <= IDLE;
      window_p0 <= '0;
      rk_p0     <= '0;
      idx_p0    <= '0;
      vld_p0    <= 1'b0;
    end else begin
      state_p0  <= state_nx;
      window_p0 <= window_nx;
      rk_p0     <= rk_nx;
      idx_p0    <= idx_nx;
      vld_p0    <= vld_nx;
    end
  end

`ifdef AES256_KEY_SCHEDULE_CACHE_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cache_vld_p0 <= 1'b0;
      replay_p0    <= 1'b0;
    end else begin
      cache_vld_p0 <= cache_vld_nx;
      replay_p0    <= replay_nx;
    end
  end

  always_ff @(posedge Clk) begin
    if (store_we) store_mem[idx_nx] <= rk_nx;
  end
`endif

  assign bus.Key_ready       = (state_p0 == IDLE);
  assign bus.Round_key       = rk_p0;
  assign bus.Round_key_index = idx_p0;
  assign bus.Round_key_last  = is_last;
  assign bus.Round_key_valid = vld_p0;

endmodule

// File: tb/tb_aes256_key_schedule_seq.sv
// Directed scoreboard bench for aes256_key_schedule_seq (FIPS-197 A.3 and all-zero keys).
module tb_aes256_key_schedule_seq;
  import aes_key_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aes256_key_schedule_seq_if bus ();

  aes256_key_schedule_seq dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [127:0] rk;
    logic [3:0]   idx;
    logic         last;
    bit           chk;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  localparam logic [127:0] FIPS_RK [15] = '{
    128'h000102030405060708090a0b0c0d0e0f, 128'h101112131415161718191a1b1c1d1e1f,
    128'ha573c29fa176c498a97fce93a572c09c, 128'h1651a8cd0244beda1a5da4c10640bade,
    128'hae87dff00ff11b68a68ed5fb03fc1567, 128'h6de1f1486fa54f9275f8eb5373b8518d,
    128'hc656827fc9a799176f294cec6cd5598b, 128'h3de23a75524775e727bf9eb45407cf39,
    128'h0bdc905fc27b0948ad5245a4c1871c2f, 128'h45f5a66017b2d387300d4d33640a820a,
    128'h7ccff71cbeb4fe5413e6bbf0d261a7df, 128'hf01afafee7a82979d7a5644ab3afe640,
    128'h2541fe719bf500258813bbd55a721c0a, 128'h4e5a6699a9f24fe07e572baacdf8cdea,
    128'h24fc79ccbf0979e9371ac23c6d68de36
  };

  localparam logic [127:0] ZERO_RK [5] = '{
    128'h0, 128'h0,
    128'h62636363626363636263636362636363, 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb,
    128'h6f6c6ccf0d0f0fac6f6c6ccf0d0f0fac
  };

  logic [255:0] fips_key;

  // Published vectors list byte 0 first; the bus carries byte 0 in bits [7:0].
  function automatic logic [127:0] le(input logic [127:0] f);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = f[8*(15-i) +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fips();
    for (int i = 0; i < 15; i++) sbq.push_back('{le(FIPS_RK[i]), 4'(i), (i == 14), 1'b1});
  endtask

  task automatic push_zero();
    for (int i = 0; i < 15; i++)
      sbq.push_back('{(i < 5) ? le(ZERO_RK[(i < 5) ? i : 0]) : 128'h0, 4'(i), (i == 14), (i < 5)});
  endtask

  task automatic load_key(input logic [255:0] k);
    int n = 0;
    while (!bus.Key_ready && n < 100) begin
      cyc();
      n++;
    end
    chk("key_ready_idle", 128'(bus.Key_ready), 128'(1));
    bus.Key       = k;
    bus.Key_valid = 1'b1;
    cyc();
    bus.Key_valid = 1'b0;
    chk("key_ready_drop", 128'(bus.Key_ready), 128'(0));
    chk("rk0_valid", 128'(bus.Round_key_valid), 128'(1));
  endtask

  task automatic drain(input bit rnd, input int inj_at, input int abort_at);
    int           cyc_n   = 0;
    int           hs      = 0;
    bit           stalled = 1'b0;
    bit           aborted = 1'b0;
    logic [127:0] sv_rk   = '0;
    logic [3:0]   sv_idx  = '0;
    exp_t         e;
    while (sbq.size() > 0 && cyc_n < 2000 && !aborted) begin
      bus.Round_key_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.Key_valid = (inj_at >= 0) && bus.Round_key_valid && (bus.Round_key_index == 4'(inj_at));
      bus.Key       = {8{32'hdeadbeef}};
      if (abort_at >= 0 && bus.Round_key_valid && bus.Round_key_index == 4'(abort_at)) begin
        rst = 1'b1;
        #1;
        chk("abort_key_ready", 128'(bus.Key_ready), 128'(1));
        chk("abort_valid", 128'(bus.Round_key_valid), 128'(0));
        chk("abort_rk", bus.Round_key, 128'h0);
        chk("abort_idx", 128'(bus.Round_key_index), 128'(0));
        chk("abort_last", 128'(bus.Round_key_last), 128'(0));
        #2;
        rst = 1'b0;
        sbq.delete();
        aborted = 1'b1;
      end else begin
        if (stalled) begin
          chk("stall_rk", bus.Round_key, sv_rk);
          chk("stall_idx", 128'(bus.Round_key_index), 128'(sv_idx));
        end
        if (bus.Round_key_valid && bus.Round_key_ready) begin
          e = sbq.pop_front();
          if (e.chk) chk($sformatf("rk%0d", e.idx), bus.Round_key, e.rk);
          chk("rk_idx", 128'(bus.Round_key_index), 128'(e.idx));
          chk("rk_last", 128'(bus.Round_key_last), 128'(e.last));
          hs++;
          stalled = 1'b0;
        end else begin
          stalled = bus.Round_key_valid;
        end
        sv_rk  = bus.Round_key;
        sv_idx = bus.Round_key_index;
        cyc();
        cyc_n++;
      end
    end
    bus.Key_valid       = 1'b0;
    bus.Round_key_ready = 1'b0;
    if (!aborted) begin
      chk("drain_timeout", 128'(sbq.size()), 128'(0));
      chk("hs_count", 128'(hs), 128'(15));
      if (!rnd) chk("hs_cycles", 128'(cyc_n), 128'(15));
      chk("done_key_ready", 128'(bus.Key_ready), 128'(1));
      chk("done_valid", 128'(bus.Round_key_valid), 128'(0));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) fips_key[8*i +: 8] = 8'(i);
    bus.Key             = '0;
    bus.Key_valid       = 1'b0;
    bus.Round_key_ready = 1'b0;
    bus.Replay          = 1'b0;
    #1 rst = 1'b1;
    #10;
    chk("rst_key_ready", 128'(bus.Key_ready), 128'(1));
    chk("rst_valid", 128'(bus.Round_key_valid), 128'(0));
    chk("rst_rk", bus.Round_key, 128'h0);
    chk("rst_idx", 128'(bus.Round_key_index), 128'(0));
    chk("rst_last", 128'(bus.Round_key_last), 128'(0));
    #2 rst = 1'b0;
    cyc();

    // FIPS key, continuous ready
    push_fips();
    load_key(fips_key);
    drain(1'b0, -1, -1);

`ifdef AES256_KEY_SCHEDULE_CACHE_EN
    bus.Replay = 1'b1;
    cyc();
    bus.Replay = 1'b0;
    chk("replay_valid", 128'(bus.Round_key_valid), 128'(1));
    push_fips();
    drain(1'b0, -1, -1);
`else
    bus.Replay = 1'b1;
    cyc();
    cyc();
    bus.Replay = 1'b0;
    chk("replay_ign_ready", 128'(bus.Key_ready), 128'(1));
    chk("replay_ign_valid", 128'(bus.Round_key_valid), 128'(0));
`endif

    // Random backpressure
    push_fips();
    load_key(fips_key);
    drain(1'b1, -1, -1);

    // Foreign key pulsed mid-stream
    push_fips();
    load_key(fips_key);
    drain(1'b0, 5, -1);

    // Reset at index 7, then a fresh schedule
    push_fips();
    load_key(fips_key);
    drain(1'b0, -1, 7);
    push_fips();
    load_key(fips_key);
    drain(1'b0, -1, -1);

    // Replay after reset is ignored
    rst = 1'b1;
    #2 rst = 1'b0;
    bus.Replay = 1'b1;
    cyc();
    cyc();
    bus.Replay = 1'b0;
    chk("rst_replay_ready", 128'(bus.Key_ready), 128'(1));
    chk("rst_replay_valid", 128'(bus.Round_key_valid), 128'(0));

    // Back-to-back keys
    push_zero();
    load_key(256'h0);
    drain(1'b0, -1, -1);
    push_fips();
    load_key(fips_key);
    drain(1'b0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes256_key_schedule_seq.md
Name: aes256_key_schedule_seq

Overview:
- Sequencer for the AES-256 key schedule. Accepts one 256-bit cipher key over a valid/ready handshake and emits all 15 round keys (index 0..14) in order on a 128-bit valid/ready stream.
- Keeps a sliding 256-bit window holding the two most recent round keys and feeds it to the combinational single-round expansion stage.
- Sits between the key-load interface and the round datapath; the encrypt core consumes one round key per handshake.

Parameters:
- NUM_ROUND_KEYS, 15, number of round keys emitted (AES256_NUMBER_OF_ROUNDS + 1).
- IDX_W, 4, width of the round index; equals the Round_number width of the expansion stage.

Ports:
- Clk  input  1  clock
- Rst  input  1  asynchronous, active-high reset
- Key  input  256  cipher key; codebase AES byte layout, byte 0 in bits [7:0]
- Key_valid  input  1  Key is valid
- Key_ready  output  1  high only in IDLE
- Round_key  output  128  current round key
- Round_key_index  output  IDX_W  index (0..14) of Round_key
- Round_key_last  output  1  high when index == 14
- Round_key_valid  output  1  Round_key is valid
- Round_key_ready  input  1  consumer accepts the round key
- Replay  input  1  re-emit the cached schedule (active only with the optional feature)

Behaviour:
- Reset (asynchronous): state IDLE; Key_ready=1; Round_key_valid=0; Round_key=0; Round_key_index=0; Round_key_last=0; window=0; cache-valid flag=0.
- IDLE, Key_valid=1 at edge T: latch Key into window W (W words 1-4 = Key words 1-4, words 5-8 = Key words 5-8). Registers Round_key=Key words 1-4, index=0, valid=1. Goes to EMIT. At T+1, Key_ready=0 and round key 0 is valid.
- EMIT, Round_key_valid & Round_key_ready with index i<14 (advance to i+1 at next edge):
  - i+1 == 1: Round_key <= W words 5-8; W unchanged.
  - i+1 >= 2: Round_key <= expansion(Round_number=i+1, Input_key=W); W <= {W words 5-8, new key}. W always holds {rk[i-1], rk[i]}.
  - Index increments; Round_key_valid stays 1.
- EMIT, ready low: Round_key, index and valid are held stable. No state change and no recomputation.
- Handshake with index 14 (last): next edge Round_key_valid=0, state IDLE, Key_ready=1. With the feature enabled, set cache-valid.
- Throughput: one round key per cycle under continuous ready; 15 handshakes per key.
- Key_valid while not IDLE is ignored; the key is not latched.
- Rst mid-stream: immediate abort, all reset values; the partial schedule is discarded.
- Round_number driven to the expansion stage is always i+1 (range 2..14). Its rcon/odd-even selection is not duplicated here.
- Replay is ignored without the feature.

Optional Feature:
- Macro: AES256_KEY_SCHEDULE_CACHE_EN.
- Enabled:
  - 15x128 key store written with each emitted round key.
  - Cache-valid is set on completion of a full schedule; it is cleared by Rst and by a new Key load.
  - Replay=1 in IDLE with cache-valid=1 enters EMIT and streams keys 0..14 from the store. Timing and handshake are identical; the expansion stage is not used.
  - Key_valid has priority over a simultaneous Replay.
- Disabled: no store and no flag; Replay is ignored; area is the window plus the output register only.

Decomposition:
- Package aes_key_sched_pkg:
  - state enum {IDLE, EMIT}
  - NUM_ROUND_KEYS, IDX_W constants
  - width constants reusing AES256_KEY_LENGTH, AES_BLOCK_SIZE, AES_WORD_SIZE
- Sub-module: one instance of aes256_key_expansion_port (combinational next-key generator).

Test Plan:
- FIPS-197 A.3 key 000102..1f, ready held 1:
  - rk0 = 00010203..0c0d0e0f, rk1 = 10111213..1c1d1e1f.
  - rk2 = a573c29fa176c498a97fce93a572c09c, rk3 = 1651a8cd0244beda1a5da4c10640bade.
  - rk14 = 24fc79ccbf0979e9371ac23c6d68de36 with last=1.
  - Exactly 15 handshakes on consecutive cycles; Key_ready returns 1 one cycle after the last handshake.
- Random backpressure on Round_key_ready: output is stable while stalled, and the sequence matches the first scenario bit-exactly.
- Key_valid pulsed with a different key mid-stream: ignored; the stream continues with the original key's values.
- Rst asserted at index 7: outputs go to reset values asynchronously. A new key afterwards produces a correct full schedule from rk0.
- Back-to-back keys (all-zero key, then 000102..1f): all-zero rk2 = 62636363626363636263636362636363. The second schedule is correct with no cross-contamination.
- CACHE_EN: after the first scenario, Replay -> identical 15 keys. Replay after Rst -> ignored; Key_ready stays 1, valid stays 0.
